// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit for a small MIPS-like core.
// Sequences FETCH/DCD/EXE/MEM/WB per instruction, decodes the datapath
// controls from state and instruction fields, and counts retired instructions.
module ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        MemRdy,
    output logic        PCWr,
    output logic [1:0]  NPCOp,
    output logic        IRWr,
    output logic        MemRd,
    output logic        MemWr,
    output logic        RegWr,
    output logic [1:0]  ALUOp,
    output logic [31:0] InstrCnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_OR   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DCD,
        S_EXE,
        S_MEM,
        S_WB
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_cnt_q;
    logic        retire;

    logic is_addu, is_subu, is_ori, is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_alu_wb;

    assign is_addu   = (Op == OP_RTYPE) && (Funct == FN_ADDU);
    assign is_subu   = (Op == OP_RTYPE) && (Funct == FN_SUBU);
    assign is_ori    = (Op == OP_ORI);
    assign is_lw     = (Op == OP_LW);
    assign is_sw     = (Op == OP_SW);
    assign is_beq    = (Op == OP_BEQ);
    assign is_j      = (Op == OP_J);
    assign is_jal    = (Op == OP_JAL);
    assign is_alu_wb = is_addu || is_subu || is_ori;

    assign InstrCnt = instr_cnt_q;

    // Next state, retire strobe and datapath controls; reset masks every control.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        PCWr    = 1'b0;
        NPCOp   = NPC_SEQ;
        IRWr    = 1'b0;
        MemRd   = 1'b0;
        MemWr   = 1'b0;
        RegWr   = 1'b0;
        ALUOp   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                MemRd = 1'b1;
                if (MemRdy) begin
                    IRWr    = 1'b1;
                    PCWr    = 1'b1;
                    state_d = S_DCD;
                end
            end
            S_DCD: begin
                if (is_j || is_jal) begin
                    PCWr    = 1'b1;
                    NPCOp   = NPC_JMP;
                    RegWr   = is_jal;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (is_subu || is_beq) ALUOp = ALU_SUB;
                else if (is_ori)       ALUOp = ALU_OR;
                if (is_alu_wb) begin
                    state_d = S_WB;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    // beq resolves here; anything unsupported retires as a NOP
                    if (is_beq) begin
                        PCWr  = Zero;
                        NPCOp = NPC_BR;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                MemRd = is_lw;
                MemWr = is_sw;
                if (MemRdy) begin
                    if (is_lw) begin
                        state_d = S_WB;
                    end else begin
                        retire  = is_sw;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                RegWr   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            PCWr  = 1'b0;
            NPCOp = NPC_SEQ;
            IRWr  = 1'b0;
            MemRd = 1'b0;
            MemWr = 1'b0;
            RegWr = 1'b0;
            ALUOp = ALU_ADD;
        end
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: randomized self-checking bench for ctrl_fsm. Each instruction
// is expanded into an expected per-cycle trace built from the instruction
// class rules, which also supplies the MemRdy/Zero stimulus for every cycle.
module tb_ctrl_fsm;

    logic        clk;
    logic        rst;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        MemRdy;
    logic        PCWr;
    logic [1:0]  NPCOp;
    logic        IRWr;
    logic        MemRd;
    logic        MemWr;
    logic        RegWr;
    logic [1:0]  ALUOp;
    logic [31:0] InstrCnt;

    ctrl_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .Op       (Op),
        .Funct    (Funct),
        .Zero     (Zero),
        .MemRdy   (MemRdy),
        .PCWr     (PCWr),
        .NPCOp    (NPCOp),
        .IRWr     (IRWr),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .RegWr    (RegWr),
        .ALUOp    (ALUOp),
        .InstrCnt (InstrCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int { K_J, K_JAL, K_BEQ, K_ALU, K_LW, K_SW, K_NOP } kind_t;

    typedef struct packed {
        logic       rdy;
        logic       zero;
        logic [8:0] exp;
    } cyc_t;

    cyc_t        trace[$];
    logic [31:0] model_cnt;
    int unsigned n_checks;
    int unsigned n_fails;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input logic pcwr, input logic [1:0] npc, input logic irwr,
                                      input logic mrd, input logic mwr, input logic rwr,
                                      input logic [1:0] alu);
        return {pcwr, npc, irwr, mrd, mwr, rwr, alu};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {PCWr, NPCOp, IRWr, MemRd, MemWr, RegWr, ALUOp};
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:   return (fn == 6'h21 || fn == 6'h23) ? K_ALU : K_NOP;
            6'h02:   return K_J;
            6'h03:   return K_JAL;
            6'h04:   return K_BEQ;
            6'h0D:   return K_ALU;
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            default: return K_NOP;
        endcase
    endfunction

    task automatic push_cyc(input logic rdy, input logic z, input logic [8:0] e);
        cyc_t c;
        c.rdy  = rdy;
        c.zero = z;
        c.exp  = e;
        trace.push_back(c);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // zsel: 0/1 forces Zero in the execute cycle, 2 randomizes it
    task automatic build_trace(input logic [5:0] op, input logic [5:0] fn,
                               input int unsigned fw, input int unsigned mw, input int zsel);
        kind_t      k;
        logic [1:0] alu;
        logic       z;
        k = classify(op, fn);
        if (op == 6'h0D)                        alu = 2'b10;
        else if (op == 6'h04)                   alu = 2'b01;
        else if (op == 6'h00 && fn == 6'h23)    alu = 2'b01;
        else                                    alu = 2'b00;
        trace.delete();
        for (int unsigned i = 0; i < fw; i++) push_cyc(1'b0, rbit(), mk(0, 2'b00, 0, 1, 0, 0, 2'b00));
        push_cyc(1'b1, rbit(), mk(1, 2'b00, 1, 1, 0, 0, 2'b00));
        if (k == K_J)   begin push_cyc(rbit(), rbit(), mk(1, 2'b10, 0, 0, 0, 0, 2'b00)); return; end
        if (k == K_JAL) begin push_cyc(rbit(), rbit(), mk(1, 2'b10, 0, 0, 0, 1, 2'b00)); return; end
        push_cyc(rbit(), rbit(), mk(0, 2'b00, 0, 0, 0, 0, 2'b00));
        z = (zsel == 2) ? rbit() : (zsel == 1);
        if (k == K_BEQ) begin push_cyc(rbit(), z, mk(z, 2'b01, 0, 0, 0, 0, alu)); return; end
        if (k == K_NOP) begin push_cyc(rbit(), z, mk(0, 2'b00, 0, 0, 0, 0, 2'b00)); return; end
        push_cyc(rbit(), z, mk(0, 2'b00, 0, 0, 0, 0, alu));
        if (k != K_ALU) begin
            for (int unsigned i = 0; i <= mw; i++)
                push_cyc(i == mw, rbit(), mk(0, 2'b00, 0, k == K_LW, k == K_SW, 0, 2'b00));
            if (k == K_SW) return;
        end
        push_cyc(rbit(), rbit(), mk(0, 2'b00, 0, 0, 0, 1, 2'b00));
    endtask

    // abort_at >= 0 stops after checking that cycle, leaving the instruction unfinished
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int unsigned fw,
                             input int unsigned mw, input int zsel, input int abort_at);
        build_trace(op, fn, fw, mw, zsel);
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clk);
            Op     = op;
            Funct  = fn;
            MemRdy = trace[i].rdy;
            Zero   = trace[i].zero;
            #1;
            check_eq($sformatf("outs op=%h fn=%h cyc=%0d", op, fn, i), 32'(dut_outs()), 32'(trace[i].exp));
            check_eq("instr_cnt", InstrCnt, model_cnt);
            if (i == abort_at) return;
            @(posedge clk);
        end
        model_cnt = model_cnt + 32'd1;
    endtask

    // called away from a clock edge; leaves rst low with MemRdy low
    task automatic apply_reset();
        #1 rst = 1'b1;
        MemRdy = 1'b1;
        #1;
        check_eq("rst_outs_immediate", 32'(dut_outs()), 32'h0);
        check_eq("rst_cnt_immediate", InstrCnt, 32'h0);
        @(posedge clk);
        #1;
        check_eq("rst_outs_held", 32'(dut_outs()), 32'h0);
        check_eq("rst_cnt_held", InstrCnt, 32'h0);
        @(negedge clk);
        MemRdy    = 1'b0;
        rst       = 1'b0;
        model_cnt = '0;
    endtask

    function automatic logic [5:0] rand_unknown_op();
        logic [5:0] o;
        do o = 6'($urandom_range(0, 63));
        while (o == 6'h00 || o == 6'h02 || o == 6'h03 || o == 6'h04 ||
               o == 6'h0D || o == 6'h23 || o == 6'h2B);
        return o;
    endfunction

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         sel;
        n_checks  = 0;
        n_fails   = 0;
        model_cnt = '0;
        rst       = 1'b1;
        Op        = 6'h00;
        Funct     = 6'h00;
        Zero      = 1'b0;
        MemRdy    = 1'b1;
        #2;
        check_eq("por_outs", 32'(dut_outs()), 32'h0);
        check_eq("por_cnt", InstrCnt, 32'h0);
        @(negedge clk);
        apply_reset();

        // directed scenarios
        run_instr(6'h00, 6'h21, 0, 0, 2, -1);     // addu
        run_instr(6'h23, 6'h00, 0, 3, 2, -1);     // lw, 3 MEM wait cycles
        run_instr(6'h04, 6'h00, 0, 0, 1, -1);     // beq taken
        run_instr(6'h04, 6'h00, 0, 0, 0, -1);     // beq not taken
        run_instr(6'h03, 6'h00, 0, 0, 2, -1);     // jal
        run_instr(6'h02, 6'h00, 2, 0, 2, -1);     // j, slow fetch
        run_instr(6'h00, 6'h23, 1, 0, 2, -1);     // subu
        run_instr(6'h0D, 6'h00, 0, 0, 2, -1);     // ori
        run_instr(6'h00, 6'h3F, 0, 0, 2, -1);     // unsupported funct
        run_instr(6'h2B, 6'h00, 0, 3, 2, 4);      // sw stalled in MEM, then reset
        #1 check_eq("sw_memwr_before_rst", 32'(MemWr), 32'h1);
        apply_reset();
        run_instr(6'h2B, 6'h00, 0, 1, 2, -1);     // sw completes after reset

        // counter wrap: preset while idling in FETCH
        @(negedge clk);
        MemRdy = 1'b0;
        force dut.instr_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.instr_cnt_q;
        #1;
        check_eq("cnt_preset", InstrCnt, 32'hFFFF_FFFE);
        check_eq("fetch_wait_outs", 32'(dut_outs()), 32'(mk(0, 2'b00, 0, 1, 0, 0, 2'b00)));
        model_cnt = 32'hFFFF_FFFE;
        @(posedge clk);
        run_instr(6'h3F, 6'h00, 0, 0, 2, -1);
        run_instr(6'h3F, 6'h00, 0, 0, 2, -1);
        #1 check_eq("cnt_wrapped", InstrCnt, 32'h0);

        // randomized instruction stream with occasional mid-instruction resets
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom_range(0, 63));
            case (sel)
                0: begin op = 6'h00; fn = rbit() ? 6'h21 : 6'h23; end
                1: op = 6'h00;
                2: op = 6'h02;
                3: op = 6'h03;
                4: op = 6'h04;
                5: op = 6'h0D;
                6: op = 6'h23;
                7: op = 6'h2B;
                default: op = rand_unknown_op();
            endcase
            if ($urandom_range(0, 19) == 0) begin
                run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2,
                          $urandom_range(0, 2));
                apply_reset();
            end else begin
                run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2, -1);
            end
        end
        #1 check_eq("final_cnt", InstrCnt, model_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 Op  input  6  opcode field of the current instruction (IR[31:26]).
REQ-004 Funct  input  6  function field (IR[5:0]), used only when Op=6'h00.
REQ-005 Zero  input  1  ALU zero flag, valid in EXE.
REQ-006 MemRdy  input  1  memory handshake, high when the current read or write completes this cycle.
REQ-007 PCWr  output  1  PC write enable.
REQ-008 NPCOp  output  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target.
REQ-009 IRWr  output  1  instruction register write enable.
REQ-010 MemRd  output  1  memory read request.
REQ-011 MemWr  output  1  memory write request.
REQ-012 RegWr  output  1  register file write enable.
REQ-013 ALUOp  output  2  00 add, 01 sub, 10 or.
REQ-014 InstrCnt  output  32  count of retired instructions.

Function
REQ-015 States: FETCH, DCD, EXE, MEM, WB; state register 3 bits; all outputs decoded combinationally from state, Op, Funct, Zero, MemRdy.
REQ-016 FETCH: MemRd=1; hold in FETCH while MemRdy=0; when MemRdy=1 assert IRWr=1, PCWr=1, NPCOp=00, then go to DCD.
REQ-017 DCD: Op=6'h02 (j) -> PCWr=1, NPCOp=10, retire, go to FETCH; Op=6'h03 (jal) -> PCWr=1, NPCOp=10, RegWr=1, retire, go to FETCH; every other opcode -> go to EXE.
REQ-018 EXE: R-type addu (Funct 6'h21) ALUOp=00; subu (Funct 6'h23) ALUOp=01; ori (6'h0D) ALUOp=10; lw (6'h23)/sw (6'h2B) ALUOp=00; beq (6'h04) ALUOp=01.
REQ-019 EXE transitions: R-type/ori -> WB; lw/sw -> MEM; beq -> PCWr=Zero, NPCOp=01, retire, go to FETCH.
REQ-020 MEM: lw drives MemRd=1, sw drives MemWr=1; hold in MEM while MemRdy=0; on MemRdy=1, lw -> WB, sw -> retire, go to FETCH.
REQ-021 WB: RegWr=1 for exactly one cycle, retire, go to FETCH.
REQ-022 Unsupported opcode, or R-type with unsupported Funct: treated as NOP; DCD -> EXE -> retire, go to FETCH; no RegWr, MemWr or PCWr.
REQ-023 Retire: InstrCnt increments by 1 on the clock edge that leaves the final state of an instruction; wraps from 32'hFFFF_FFFF to 0.
REQ-024 Outputs not listed as asserted in a state are 0; PCWr is never asserted in MEM or WB.
REQ-025 Cycle counts with MemRdy tied high: j/jal 2, beq/NOP 3, R-type/ori/sw 4, lw 5.
REQ-026 MemRdy is sampled only in FETCH and MEM and is ignored in all other states.

Reset
REQ-027 rst=1 forces state=FETCH and InstrCnt=0 immediately, without waiting for a clock edge.
REQ-028 While rst=1, all enable outputs (PCWr, IRWr, MemRd, MemWr, RegWr) are 0, NPCOp=00 and ALUOp=00.
REQ-029 Reset asserted mid-instruction (any state, including a pending MemRdy wait) abandons that instruction without retiring it; after rst falls, the first rising edge evaluates FETCH.

Verification
REQ-030 Reset, MemRdy=1, addu (Op 00, Funct 21) -> IRWr/PCWr pulse in cycle 1, RegWr=1 in cycle 4 only, ALUOp=00 in EXE, InstrCnt=1 after cycle 4.
REQ-031 lw with MemRdy low for 3 MEM cycles -> MemRd=1 held 4 cycles in MEM, RegWr=1 in the following cycle, instruction takes 8 cycles.
REQ-032 beq with Zero=1 -> PCWr=1, NPCOp=01 in EXE; same instruction with Zero=0 -> PCWr=0; both take 3 cycles.
REQ-033 jal -> PCWr=1, NPCOp=10, RegWr=1 in DCD; FETCH on the next cycle; InstrCnt+1.
REQ-034 rst pulsed while in MEM waiting on sw -> MemWr drops to 0 immediately, InstrCnt=0, FETCH after rst falls.
REQ-035 InstrCnt preset to 32'hFFFF_FFFE via force, then 2 NOP instructions retired -> InstrCnt=0; unknown Op 6'h3F -> no writes, 3 cycles.
